// File: rtl/sp_sync_fifo.sv
// sp_sync_fifo: single-clock FIFO (DEPTH x DATA_W) with registered read data.
// Define SP_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sp_sync_fifo #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
`ifdef SP_FIFO_ERR_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr_count;
    logic [ADDR_W-1:0] rd_addr_count;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come from the occupancy counter, never from pointer equality.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr_count] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_count <= '0;
            rd_addr_count <= '0;
            dout          <= '0;
            count         <= '0;
        end else begin
            if (wr_ok)
                wr_addr_count <= wr_addr_count + ADDR_W'(1);
            if (rd_ok) begin
                dout          <= mem[rd_addr_count];
                rd_addr_count <= rd_addr_count + ADDR_W'(1);
            end
            if (wr_ok && !rd_ok)
                count <= count + CNT_W'(1);
            else if (rd_ok && !wr_ok)
                count <= count - CNT_W'(1);
        end
    end

`ifdef SP_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_sync_fifo.sv
// Self-checking bench for sp_sync_fifo: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_sp_sync_fifo;

    logic       clk = 1'b1;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef SP_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    // Rising edges at 10, 20, ...; inputs driven and outputs sampled on falling edges.
    always #5 clk = ~clk;

    sp_sync_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .din      (din),
        .rd_en    (rd_en),
        .dout     (dout),
        .full     (full),
        .empty    (empty),
`ifdef SP_FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .count    (count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: contents as a queue, pointers as modulo-16 counters.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    int         m_wp   = 0;
    int         m_rp   = 0;
    logic       m_ovf  = 1'b0;
    logic       m_udf  = 1'b0;

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bit m_full;
        bit m_empty;
        m_full  = (q.size() == 16);
        m_empty = (q.size() == 0);
        wr_en = w; rd_en = r; din = d;
        if (w && m_full)  m_ovf = 1'b1;
        if (r && m_empty) m_udf = 1'b1;
        if (r && !m_empty) begin
            m_dout = q.pop_front();
            m_rp   = (m_rp + 1) % 16;
        end
        if (w && !m_full) begin
            q.push_back(d);
            m_wp = (m_wp + 1) % 16;
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        #12;
        n_chk++;
        if ({full, empty, count} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL reset_flags: full/empty/count got %b/%b/%0d want 0/1/0", full, empty, count);
        else n_pass++;
        n_chk++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout);
        else n_pass++;
        n_chk++;
        if ({dut.wr_addr_count, dut.rd_addr_count} !== 8'h00)
            $display("FAIL reset_ptrs: got wp=%0d rp=%0d want 0/0", dut.wr_addr_count, dut.rd_addr_count);
        else n_pass++;
`ifdef SP_FIFO_ERR_EN
        n_chk++;
        if ({overflow, underflow} !== 2'b00)
            $display("FAIL reset_err: got ovf=%b udf=%b want 0/0", overflow, underflow);
        else n_pass++;
`endif
        #3 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if ({full, empty, count} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL reset_release: full/empty/count got %b/%b/%0d want 0/1/0", full, empty, count);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            n_chk++;
            if ({full, empty, count} !== {(i == 15), 1'b0, 5'(i + 1)})
                $display("FAIL fill_%0d: full/empty/count got %b/%b/%0d want %b/0/%0d",
                         i, full, empty, count, (i == 15), i + 1);
            else n_pass++;
        end
        n_chk++;
        if (dut.wr_addr_count !== 4'(m_wp))
            $display("FAIL fill_wp_wrap: got %0d want %0d", dut.wr_addr_count, m_wp);
        else n_pass++;
        step(1'b1, 1'b0, 8'hFF);
        n_chk++;
        if ({full, count, dut.wr_addr_count, dout} !== {1'b1, 5'd16, 4'(m_wp), 8'h00})
            $display("FAIL fill_overwrite: full/count/wp/dout got %b/%0d/%0d/%h want 1/16/%0d/00",
                     full, count, dut.wr_addr_count, dout, m_wp);
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_chk++;
            if (dout !== 8'(i)) $display("FAIL drain_dout_%0d: got %h want %h", i, dout, 8'(i));
            else n_pass++;
            n_chk++;
            if ({full, empty, count} !== {1'b0, (i == 15), 5'(15 - i)})
                $display("FAIL drain_flags_%0d: full/empty/count got %b/%b/%0d want 0/%b/%0d",
                         i, full, empty, count, (i == 15), 15 - i);
            else n_pass++;
        end
        n_chk++;
        if (dut.rd_addr_count !== 4'(m_rp))
            $display("FAIL drain_rp_wrap: got %0d want %0d", dut.rd_addr_count, m_rp);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_chk++;
            if ({dout, count, empty} !== {8'h0F, 5'd0, 1'b1})
                $display("FAIL drain_underread_%0d: dout/count/empty got %h/%0d/%b want 0f/0/1",
                         i, dout, count, empty);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i));
            n_chk++;
            if ({count, dout} !== {5'd8, m_dout})
                $display("FAIL simul_%0d: count/dout got %0d/%h want 8/%h", i, count, dout, m_dout);
            else n_pass++;
        end
        n_chk++;
        if ({dut.wr_addr_count, dut.rd_addr_count} !== {4'(m_wp), 4'(m_rp)})
            $display("FAIL simul_ptrs: got wp=%0d rp=%0d want %0d/%0d",
                     dut.wr_addr_count, dut.rd_addr_count, m_wp, m_rp);
        else n_pass++;
    endtask

    task automatic test_wr_rd_empty();
        logic [7:0] prev;
        while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
        prev = m_dout;
        step(1'b1, 1'b1, 8'hA5);
        n_chk++;
        if ({dout, count} !== {prev, 5'd1})
            $display("FAIL empty_wrrd: dout/count got %h/%0d want %h/1", dout, count, prev);
        else n_pass++;
        step(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({dout, empty} !== {8'hA5, 1'b1})
            $display("FAIL empty_wrrd_next: dout/empty got %h/%b want a5/1", dout, empty);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            // Alternate write-heavy and read-heavy phases so both full and empty are hit.
            int wp = ((i / 50) % 2) ? 25 : 80;
            step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp + 10)), 8'($urandom));
            n_chk++;
            if ({full, empty, count, dout} !== {(q.size() == 16), (q.size() == 0), 5'(q.size()), m_dout})
                $display("FAIL rand_%0d: full/empty/count/dout got %b/%b/%0d/%h want %b/%b/%0d/%h",
                         i, full, empty, count, dout, (q.size() == 16), (q.size() == 0), q.size(), m_dout);
            else n_pass++;
            n_chk++;
            if ({dut.wr_addr_count, dut.rd_addr_count} !== {4'(m_wp), 4'(m_rp)})
                $display("FAIL rand_ptrs_%0d: got wp=%0d rp=%0d want %0d/%0d",
                         i, dut.wr_addr_count, dut.rd_addr_count, m_wp, m_rp);
            else n_pass++;
`ifdef SP_FIFO_ERR_EN
            n_chk++;
            if ({overflow, underflow} !== {m_ovf, m_udf})
                $display("FAIL rand_err_%0d: got ovf=%b udf=%b want %b/%b", i, overflow, underflow, m_ovf, m_udf);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_async_reset();
        while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77);
        n_chk++;
        if ({count, dout} !== {5'd5, 8'h10})
            $display("FAIL areset_pre: count/dout got %0d/%h want 5/10", count, dout);
        else n_pass++;
`ifdef SP_FIFO_ERR_EN
        n_chk++;
        if (overflow !== 1'b1) $display("FAIL areset_pre_ovf: got %b want 1", overflow);
        else n_pass++;
`endif
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({count, empty, full, dout} !== {5'd0, 1'b1, 1'b0, 8'h00})
            $display("FAIL areset_immediate: count/empty/full/dout got %0d/%b/%b/%h want 0/1/0/00",
                     count, empty, full, dout);
        else n_pass++;
        n_chk++;
        if ({dut.wr_addr_count, dut.rd_addr_count} !== 8'h00)
            $display("FAIL areset_ptrs: got wp=%0d rp=%0d want 0/0", dut.wr_addr_count, dut.rd_addr_count);
        else n_pass++;
`ifdef SP_FIFO_ERR_EN
        n_chk++;
        if ({overflow, underflow} !== 2'b00)
            $display("FAIL areset_err: got ovf=%b udf=%b want 0/0", overflow, underflow);
        else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
        q.delete(); m_dout = 8'h00; m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({dout, empty} !== {8'h3C, 1'b1})
            $display("FAIL areset_after: dout/empty got %h/%b want 3c/1", dout, empty);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wr_rd_empty();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
